// File: rtl/mux_arb_pkg.sv
// rtl/mux_arb_pkg.sv - shared types and select-width helper for the mux select arbiter
package mux_arb_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   function automatic int sel_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// rtl/rr_priority_pick.sv - combinational round-robin pick: first set request at or above the pointer, wrapping
module rr_priority_pick
   import mux_arb_pkg::*;
#(
   parameter int N     = 4,
   parameter int SEL_W = sel_width(N)
) (
   input  logic [N-1:0]     request,
   input  logic [SEL_W-1:0] pointer,
   output logic [SEL_W-1:0] winner,
   output logic             any
);

   logic [SEL_W-1:0] idx;

   // Scan downward so the last hit written is the one closest above the pointer.
   always_comb begin
      winner = '0;
      idx    = '0;
      any    = |request;
      for (int i = N - 1; i >= 0; i--) begin
         idx = SEL_W'((int'(pointer) + i) % N);
         if (request[idx]) winner = idx;
      end
   end

endmodule

// File: rtl/mux_select_arbiter.sv
// rtl/mux_select_arbiter.sv - round-robin arbiter driving a shared N:1 mux select with a registered output lane
// Optional forced-release timeout enabled by defining MUX_ARB_TIMEOUT_EN.
module mux_select_arbiter
   import mux_arb_pkg::*;
#(
   parameter int N        = 4,
   parameter int W        = 8,
   parameter int HOLD_MAX = 16,
   localparam int SEL_W   = sel_width(N)
) (
   input  logic             i_Clock,
   input  logic             i_Reset,
   input  logic [N-1:0]     i_Request,
   input  logic [N*W-1:0]   i_Data,
   output logic [N-1:0]     o_Grant,
   output logic [SEL_W-1:0] o_Select,
   output logic [W-1:0]     o_Data,
   output logic             o_Valid,
   output logic             o_Preempt
);

   if (N < 2) begin : g_bad_n
      $error("mux_select_arbiter: N must be at least 2");
   end
   if (HOLD_MAX < 1) begin : g_bad_hold
      $error("mux_select_arbiter: HOLD_MAX must be at least 1");
   end

   state_t           state;
   logic [N-1:0]     grant;
   logic [SEL_W-1:0] sel;
   logic [SEL_W-1:0] pointer;
   logic [W-1:0]     data;
   logic             valid;
   logic [SEL_W-1:0] winner;
   logic             any;
   logic [SEL_W-1:0] next_pointer;
   logic             owner_req;
   logic             timeout;

   rr_priority_pick #(.N(N), .SEL_W(SEL_W)) u_pick (
      .request (i_Request),
      .pointer (pointer),
      .winner  (winner),
      .any     (any)
   );

   assign next_pointer = (winner == SEL_W'(N - 1)) ? '0 : winner + 1'b1;
   assign owner_req    = i_Request[sel];

`ifdef MUX_ARB_TIMEOUT_EN
   localparam int HOLD_W = $clog2(HOLD_MAX + 1);

   logic [HOLD_W-1:0] hold_cnt;
   logic              preempt;

   // The cycle that reaches HOLD_MAX beats is also the owner's last captured beat.
   assign timeout = (state == GRANT) && (hold_cnt == HOLD_W'(HOLD_MAX - 1));

   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) begin
         hold_cnt <= '0;
         preempt  <= 1'b0;
      end else begin
         preempt <= (state == GRANT) && owner_req && timeout;
         if (state == IDLE)
            hold_cnt <= '0;
         else
            hold_cnt <= hold_cnt + 1'b1;
      end
   end

   assign o_Preempt = preempt;
`else
   assign timeout   = 1'b0;
   assign o_Preempt = 1'b0;
`endif

   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) begin
         state   <= IDLE;
         grant   <= '0;
         sel     <= '0;
         pointer <= '0;
         data    <= '0;
         valid   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               valid <= 1'b0;
               if (any) begin
                  state   <= GRANT;
                  grant   <= N'(1) << winner;
                  sel     <= winner;
                  pointer <= next_pointer;
               end
            end
            GRANT: begin
               data  <= i_Data[int'(sel)*W +: W];
               valid <= 1'b1;
               if (!owner_req || timeout) begin
                  state <= IDLE;
                  grant <= '0;
               end
            end
            default: begin
               state <= IDLE;
               grant <= '0;
               valid <= 1'b0;
            end
         endcase
      end
   end

   assign o_Grant  = grant;
   assign o_Select = sel;
   assign o_Data   = data;
   assign o_Valid  = valid;

endmodule
